mips_mem_loader: RTL and testbench
==================================

# mips_mem_loader

Boot-time loader ahead of the single-cycle MIPS core. It receives a byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and writes them into instruction memory or data memory. On a run command it releases the core, replacing `$readmemb` preloading with a synthesizable load path. Memories are byte-addressed, big-endian: byte addr, addr+1, addr+2 and addr+3 hold bits 31:24 down to 7:0.

## Interface
- `ADDR_W`, 10: memory byte-address width; word capacity is 2^(ADDR_W-2).
- `clk`  in  1  rising-edge clock, shared with the core.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_valid`  in  1  stream byte valid.
- `rx_data`  in  8  stream byte.
- `rx_ready`  out  1  loader can accept a byte.
- `im_we`  out  1  one-cycle instruction-memory word write strobe.
- `dm_we`  out  1  one-cycle data-memory word write strobe.
- `mem_addr`  out  ADDR_W  byte address of the write; always a multiple of 4.
- `mem_wdata`  out  32  word to write.
- `cpu_run`  out  1  high means the core runs; while low the core is held and PC stays 0.
- `busy`  out  1  a block is in progress.
- `error`  out  1  sticky protocol error.

## Operation
- A byte transfers on a rising edge with `rx_valid && rx_ready`.
- Block format: cmd, addr_hi, addr_lo, cnt_hi, cnt_lo, then cnt×4 data bytes.
  - cmd 0x49 ('I') targets IM; cmd 0x44 ('D') targets DM.
  - addr and cnt are 16-bit big-endian; addr is a word address.
- Cmd 0x47 ('G') is a single byte: set `cpu_run`, then go to RUN.
- Any other cmd byte goes to ERR.
- States: IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, DATA, CHK (macro only), RUN, ERR.
- On CNT_LO accept:
  - cnt==0: back to IDLE (or CHK).
  - addr+cnt > 2^(ADDR_W-2), computed 17-bit with no wrap: go to ERR; no writes issued.
  - Otherwise: go to DATA.
- DATA: byte index 0..3 shifts into a 32-bit word, MSB first. On the 4th byte, issue one write.
  - Address is `{addr_word, 2'b00}`, truncated to ADDR_W.
  - Then increment the word pointer and decrement the remaining count.
  - When remaining reaches 0, go to IDLE (or CHK).
- RUN: `rx_ready`=0; bytes are ignored. Only reset leaves RUN.
- ERR: `rx_ready`=0, `error`=1, `cpu_run`=0. Only reset leaves ERR.
- `busy`=1 in ADDR_HI through CHK.
- Reset, including mid-block, does the following:
  - State returns to IDLE.
  - The partial word is discarded.
  - Writes already issued remain in memory.

## Timing
- Reset values: `rx_ready`=0, `im_we`=`dm_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_run`=0, `busy`=0, `error`=0.
- `rx_ready` rises on the first clock after `rst_n` deasserts. It is high in IDLE through CHK and is registered.
- Write latency: 4th byte accepted at edge N gives the `*_we` pulse plus addr/data valid for the cycle after edge N. Values update at edge N, so the memory captures them at edge N+1.
- No stall: back-to-back words at one byte per cycle give one write every 4 cycles.
- `cpu_run` rises at the edge that accepts 'G'. The core's first fetch is at PC 0 on the following edge.
- `im_we` and `dm_we` are never high together.

## Configuration
- `MIPS_LOADER_CHECKSUM_EN`
  - Defined: each I/D block ends with a checksum byte, handled in state CHK. The checksum must equal the 8-bit modular sum of addr_hi, addr_lo, cnt_hi, cnt_lo and all data bytes. On a mismatch the loader enters ERR; writes already issued are kept.
  - Undefined: there is no CHK state and a block ends after its last data byte.

## Structure
- Package `mips_loader_pkg`:
  - state enum;
  - command constants CMD_IM=8'h49, CMD_DM=8'h44, CMD_GO=8'h47;
  - word byte count 4.
- Sub-module `mips_loader_word_packer`: byte shift register plus 2-bit index. It outputs `word_done` and `word`. It is cleared by `rst_n` and when a new block starts.

## Test plan
- Block I, addr 0, cnt 2, words 0x20080004 and 0x8D090000, then G:
  - `im_we` pulses with addr 0x000 then 0x004, carrying those words.
  - `cpu_run` goes to 1.
- Block D, addr 3, cnt 1, word 0xDEADBEEF:
  - one `dm_we` pulse at addr 0x00C;
  - DataMemory[12..15] = DE AD BE EF.
- Cmd 0x55 in IDLE → `error`=1, `rx_ready`=0, no write strobes; later G bytes are ignored.
- ADDR_W=10 with block addr 0x00FF, cnt 2 → ERR after cnt_lo, zero writes.
- `rst_n` pulsed after 2 data bytes, then a fresh I block addr 0 cnt 1 → a single correct write at 0x000; the partial word is lost.
- With the macro defined: correct checksum → IDLE. Checksum off by one → ERR, and earlier writes remain.

Source files
------------

// File: rtl/mips_loader_pkg.sv
// Shared definitions for the MIPS boot-time memory loader.
// Optional feature macro: MIPS_LOADER_CHECKSUM_EN adds the per-block checksum state.
package mips_loader_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_CNT_HI,
    ST_CNT_LO,
    ST_DATA,
`ifdef MIPS_LOADER_CHECKSUM_EN
    ST_CHK,
`endif
    ST_RUN,
    ST_ERR
  } state_e;

  localparam logic [7:0] CMD_IM = 8'h49;
  localparam logic [7:0] CMD_DM = 8'h44;
  localparam logic [7:0] CMD_GO = 8'h47;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/mips_loader_word_packer.sv
// Assembles four stream bytes, most significant first, into a 32-bit word.
// word_done/word are combinational so the top can register the write on the
// same edge that accepts the last byte.
module mips_loader_word_packer
  import mips_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        shift_i,
  input  logic [7:0]  data_i,
  output logic        word_done,
  output logic [31:0] word
);

  localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

  logic [23:0] sr_q, sr_d;
  logic [1:0]  idx_q, idx_d;

  // Shift in a byte per accepted data beat; a new block discards any partial word.
  always_comb begin
    sr_d  = sr_q;
    idx_d = idx_q;
    if (clr_i) begin
      sr_d  = '0;
      idx_d = '0;
    end else if (shift_i) begin
      sr_d  = {sr_q[15:0], data_i};
      idx_d = idx_q + 2'd1;
    end
  end

  // Byte shift register and index; index wraps from 3 back to 0 after each word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      idx_q <= '0;
    end else begin
      sr_q  <= sr_d;
      idx_q <= idx_d;
    end
  end

  assign word_done = shift_i && !clr_i && (idx_q == LAST_IDX);
  assign word      = {sr_q, data_i};

endmodule

// File: rtl/mips_mem_loader.sv
// Boot loader: parses I/D/G command blocks from a byte stream, writes
// big-endian words into instruction or data memory, then releases the core.
// Optional feature macro: MIPS_LOADER_CHECKSUM_EN (trailing checksum byte per block).
module mips_mem_loader
  import mips_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              im_we,
  output logic              dm_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_run,
  output logic              busy,
  output logic              error
);

  // Words the memory holds; a block may end exactly at this boundary.
  localparam logic [16:0] WORD_CAP = 17'(2 ** (ADDR_W - 2));

`ifdef MIPS_LOADER_CHECKSUM_EN
  localparam state_e ST_BLOCK_END = ST_CHK;
`else
  localparam state_e ST_BLOCK_END = ST_IDLE;
`endif

  state_e            state_q, state_d;
  logic [15:0]       addr_q, addr_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              is_im_q, is_im_d;
  logic              rx_ready_q, rx_ready_d;
  logic              im_we_q, im_we_d;
  logic              dm_we_q, dm_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              cpu_run_q, cpu_run_d;
  logic              error_q, error_d;
`ifdef MIPS_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic        accept;
  logic        pk_clr;
  logic        pk_shift;
  logic        word_done;
  logic [31:0] word;
  logic [15:0] cnt_full;
  logic [16:0] block_end;

  assign accept    = rx_valid && rx_ready_q;
  assign cnt_full  = {cnt_q[15:8], rx_data};
  // 17-bit sum so a block running past the top of memory cannot wrap into range.
  assign block_end = {1'b0, addr_q} + {1'b0, cnt_full};

  mips_loader_word_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (pk_clr),
    .shift_i   (pk_shift),
    .data_i    (rx_data),
    .word_done (word_done),
    .word      (word)
  );

  // Command parser: next state, block bookkeeping and registered write port.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    is_im_d     = is_im_q;
    im_we_d     = 1'b0;
    dm_we_d     = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_run_d   = cpu_run_q;
    pk_clr      = 1'b0;
    pk_shift    = 1'b0;
`ifdef MIPS_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          pk_clr = 1'b1;
`ifdef MIPS_LOADER_CHECKSUM_EN
          csum_d = 8'h00;
`endif
          case (rx_data)
            CMD_IM: begin
              is_im_d = 1'b1;
              state_d = ST_ADDR_HI;
            end
            CMD_DM: begin
              is_im_d = 1'b0;
              state_d = ST_ADDR_HI;
            end
            CMD_GO: begin
              cpu_run_d = 1'b1;
              state_d   = ST_RUN;
            end
            default: state_d = ST_ERR;
          endcase
        end
      end
      ST_ADDR_HI: begin
        if (accept) begin
          addr_d[15:8] = rx_data;
          state_d      = ST_ADDR_LO;
        end
      end
      ST_ADDR_LO: begin
        if (accept) begin
          addr_d[7:0] = rx_data;
          state_d     = ST_CNT_HI;
        end
      end
      ST_CNT_HI: begin
        if (accept) begin
          cnt_d[15:8] = rx_data;
          state_d     = ST_CNT_LO;
        end
      end
      ST_CNT_LO: begin
        if (accept) begin
          cnt_d = cnt_full;
          if (cnt_full == 16'd0) begin
            state_d = ST_BLOCK_END;
          end else if (block_end > WORD_CAP) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        pk_shift = accept;
        if (word_done) begin
          im_we_d     = is_im_q;
          dm_we_d     = !is_im_q;
          mem_addr_d  = {addr_q[ADDR_W-3:0], 2'b00};
          mem_wdata_d = word;
          addr_d      = addr_q + 16'd1;
          cnt_d       = cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            state_d = ST_BLOCK_END;
          end
        end
      end
`ifdef MIPS_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (accept) begin
          state_d = (rx_data == csum_q) ? ST_IDLE : ST_ERR;
        end
      end
`endif
      ST_RUN: begin
        state_d = ST_RUN;
      end
      ST_ERR: begin
        cpu_run_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef MIPS_LOADER_CHECKSUM_EN
    // Everything between the command and the checksum byte itself is summed.
    if (accept && (state_q inside {ST_ADDR_HI, ST_ADDR_LO, ST_CNT_HI, ST_CNT_LO, ST_DATA})) begin
      csum_d = csum_q + rx_data;
    end
`endif
    rx_ready_d = !(state_d inside {ST_RUN, ST_ERR});
    error_d    = (state_d == ST_ERR);
  end

  // State and output registers; reset abandons any block in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      is_im_q     <= 1'b0;
      rx_ready_q  <= 1'b0;
      im_we_q     <= 1'b0;
      dm_we_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_run_q   <= 1'b0;
      error_q     <= 1'b0;
`ifdef MIPS_LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      is_im_q     <= is_im_d;
      rx_ready_q  <= rx_ready_d;
      im_we_q     <= im_we_d;
      dm_we_q     <= dm_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_run_q   <= cpu_run_d;
      error_q     <= error_d;
`ifdef MIPS_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign rx_ready  = rx_ready_q;
  assign im_we     = im_we_q;
  assign dm_we     = dm_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_run   = cpu_run_q;
  assign error     = error_q;
  assign busy      = !(state_q inside {ST_IDLE, ST_RUN, ST_ERR});

endmodule

// File: tb/tb_mips_mem_loader.sv
// Directed testbench for mips_mem_loader with byte-level memory models.
// Honours MIPS_LOADER_CHECKSUM_EN by appending a checksum byte to each block.
module tb_mips_mem_loader;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_ready;
  logic              im_we;
  logic              dm_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_run;
  logic              busy;
  logic              error;

  int n_checks = 0;
  int n_errors = 0;
  int both_hi  = 0;

  logic [7:0] im_mem [0:(1<<ADDR_W)-1];
  logic [7:0] dm_mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] log_addr [$];
  logic [31:0]       log_data [$];
  logic              log_im   [$];
  logic [7:0]        csum_tb;

  always #5 clk = ~clk;

  mips_mem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .im_we     (im_we),
    .dm_we     (dm_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_run   (cpu_run),
    .busy      (busy),
    .error     (error)
  );

  // Memories capture the write port on the edge after the strobe is raised.
  always @(posedge clk) begin
    if (im_we && dm_we) both_hi <= both_hi + 1;
    if (im_we || dm_we) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
      log_im.push_back(im_we);
      for (int b = 0; b < 4; b++) begin
        if (im_we) im_mem[int'(mem_addr) + b] <= mem_wdata[8*(3-b) +: 8];
        else       dm_mem[int'(mem_addr) + b] <= mem_wdata[8*(3-b) +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      check("rx_ready_wait", {31'b0, rx_ready}, 32'd1);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [15:0] a, input logic [15:0] c);
    csum_tb = 8'h00;
    send_byte(cmd);
    send_byte(a[15:8]); csum_tb += a[15:8];
    send_byte(a[7:0]);  csum_tb += a[7:0];
    send_byte(c[15:8]); csum_tb += c[15:8];
    send_byte(c[7:0]);  csum_tb += c[7:0];
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) begin
      send_byte(w[8*i +: 8]);
      csum_tb += w[8*i +: 8];
    end
  endtask

  task automatic end_block(input logic [7:0] delta);
`ifdef MIPS_LOADER_CHECKSUM_EN
    send_byte(csum_tb + delta);
`else
    csum_tb = csum_tb + delta;
`endif
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    log_addr.delete();
    log_data.delete();
    log_im.delete();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    check("rst_rx_ready", {31'b0, rx_ready}, 32'd0);
    check("rst_im_we",    {31'b0, im_we},    32'd0);
    check("rst_dm_we",    {31'b0, dm_we},    32'd0);
    check("rst_mem_addr", 32'(mem_addr),     32'd0);
    check("rst_wdata",    mem_wdata,         32'd0);
    check("rst_cpu_run",  {31'b0, cpu_run},  32'd0);
    check("rst_busy",     {31'b0, busy},     32'd0);
    check("rst_error",    {31'b0, error},    32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rdy_after_rst", {31'b0, rx_ready}, 32'd1);

    // I block, two words, then GO
    send_hdr(8'h49, 16'h0000, 16'h0002);
    check("blkI_busy", {31'b0, busy}, 32'd1);
    send_word(32'h20080004);
    check("blkI_w0_we",   {31'b0, im_we}, 32'd1);
    check("blkI_w0_dmwe", {31'b0, dm_we}, 32'd0);
    check("blkI_w0_addr", 32'(mem_addr),  32'h000);
    check("blkI_w0_data", mem_wdata,      32'h20080004);
    send_word(32'h8D090000);
    check("blkI_w1_we",   {31'b0, im_we}, 32'd1);
    check("blkI_w1_addr", 32'(mem_addr),  32'h004);
    check("blkI_w1_data", mem_wdata,      32'h8D090000);
    end_block(8'h00);
    @(negedge clk);
    check("blkI_we_low", {31'b0, im_we}, 32'd0);
    check("blkI_nwr", log_addr.size(), 32'd2);
    check("blkI_mem0", {im_mem[0], im_mem[1], im_mem[2], im_mem[3]}, 32'h20080004);
    check("blkI_mem1", {im_mem[4], im_mem[5], im_mem[6], im_mem[7]}, 32'h8D090000);
    check("blkI_idle_busy", {31'b0, busy}, 32'd0);
    send_byte(8'h47);
    check("go_cpu_run", {31'b0, cpu_run}, 32'd1);
    check("go_rdy",     {31'b0, rx_ready}, 32'd0);
    check("go_busy",    {31'b0, busy}, 32'd0);
    rx_valid = 1'b1; rx_data = 8'h49;
    repeat (3) @(negedge clk);
    rx_valid = 1'b0;
    check("run_ignore_busy", {31'b0, busy}, 32'd0);
    check("run_ignore_nwr",  log_addr.size(), 32'd2);

    // D block at word address 3
    do_reset();
    check("rst_clears_run", {31'b0, cpu_run}, 32'd0);
    send_hdr(8'h44, 16'h0003, 16'h0001);
    send_word(32'hDEADBEEF);
    end_block(8'h00);
    repeat (2) @(negedge clk);
    check("blkD_nwr",  log_addr.size(), 32'd1);
    check("blkD_isim", {31'b0, log_im[0]}, 32'd0);
    check("blkD_addr", 32'(log_addr[0]), 32'h00C);
    check("blkD_mem",  {dm_mem[12], dm_mem[13], dm_mem[14], dm_mem[15]}, 32'hDEADBEEF);
    check("blkD_err",  {31'b0, error}, 32'd0);

    // Bad command byte
    do_reset();
    send_byte(8'h55);
    check("bad_err",  {31'b0, error}, 32'd1);
    check("bad_rdy",  {31'b0, rx_ready}, 32'd0);
    rx_valid = 1'b1; rx_data = 8'h47;
    repeat (4) @(negedge clk);
    rx_valid = 1'b0;
    check("bad_no_run", {31'b0, cpu_run}, 32'd0);
    check("bad_nwr",    log_addr.size(), 32'd0);
    check("bad_sticky", {31'b0, error}, 32'd1);

    // Block runs one word past the top of memory
    do_reset();
    send_hdr(8'h49, 16'h00FF, 16'h0002);
    check("ovf_err", {31'b0, error}, 32'd1);
    check("ovf_rdy", {31'b0, rx_ready}, 32'd0);
    check("ovf_nwr", log_addr.size(), 32'd0);

    // Block ends exactly at the top of memory
    do_reset();
    send_hdr(8'h49, 16'h00FF, 16'h0001);
    check("top_err", {31'b0, error}, 32'd0);
    send_word(32'hCAFEF00D);
    end_block(8'h00);
    @(negedge clk);
    check("top_nwr",  log_addr.size(), 32'd1);
    check("top_addr", 32'(log_addr[0]), 32'h3FC);
    check("top_data", log_data[0], 32'hCAFEF00D);

    // Reset mid-word discards the partial word
    do_reset();
    send_hdr(8'h49, 16'h0000, 16'h0001);
    send_byte(8'hAA);
    send_byte(8'hBB);
    do_reset();
    check("mid_busy", {31'b0, busy}, 32'd0);
    send_hdr(8'h49, 16'h0000, 16'h0001);
    send_word(32'h11223344);
    end_block(8'h00);
    repeat (2) @(negedge clk);
    check("mid_nwr",  log_addr.size(), 32'd1);
    check("mid_addr", 32'(log_addr[0]), 32'h000);
    check("mid_data", log_data[0], 32'h11223344);
    check("mid_mem",  {im_mem[0], im_mem[1], im_mem[2], im_mem[3]}, 32'h11223344);

`ifdef MIPS_LOADER_CHECKSUM_EN
    // Checksum good, then checksum off by one
    do_reset();
    send_hdr(8'h44, 16'h0004, 16'h0001);
    send_word(32'h01020304);
    end_block(8'h00);
    check("csum_ok_err",  {31'b0, error}, 32'd0);
    check("csum_ok_busy", {31'b0, busy}, 32'd0);
    check("csum_ok_rdy",  {31'b0, rx_ready}, 32'd1);
    send_hdr(8'h44, 16'h0005, 16'h0001);
    send_word(32'hA5A5A5A5);
    end_block(8'h01);
    @(negedge clk);
    check("csum_bad_err", {31'b0, error}, 32'd1);
    check("csum_bad_nwr", log_addr.size(), 32'd2);
    check("csum_keep0", {dm_mem[16], dm_mem[17], dm_mem[18], dm_mem[19]}, 32'h01020304);
    check("csum_keep1", {dm_mem[20], dm_mem[21], dm_mem[22], dm_mem[23]}, 32'hA5A5A5A5);
`endif

    check("never_both_we", both_hi, 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
